gate_response_checker: RTL
==========================

// Module: gate_response_checker
// PURPOSE
//   Synthesizable self-checking harness for 2^N-row combinational gate tests.
//   Drives every input vector onto a gate under test and samples the gate's output.
//   Compares each sample against a parameterised truth table, counts mismatches and reports pass/fail.
//   Sits beside any gate in Gate/ (and, or, xor, ...) and replaces hand-written #10 stimulus with a checked sweep.
// PARAMETERS
//   N_IN        2        gate input count; vectors 0 .. 2^N_IN-1
//   TRUTH       4'b1000  expected output; bit k = expected y for vector k (default = AND)
//   SETTLE_CYC  1        cycles vec_out is held before the check cycle; legal range >= 1
//   ERR_W       8        width of the mismatch counter
// PORTS
//   clk              in   1      rising-edge clock
//   rst_n            in   1      asynchronous active-low reset
//   start            in   1      single-cycle run request
//   dut_y            in   1      output of the gate under test
//   vec_out          out  N_IN   input vector driven to the gate under test
//   busy             out  1      high while a sweep is in progress
//   done             out  1      high from sweep end until the next accepted start
//   pass             out  1      valid while done; 1 when err_cnt == 0
//   err_cnt          out  ERR_W  mismatches in the current/last sweep; saturates at all-ones
//   first_err_valid  out  1      set on the first mismatch of a sweep
//   first_err_vec    out  N_IN   vector of the first mismatch; 0 when first_err_valid is low
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - All outputs go to 0 immediately; state=IDLE.
//     - Asserting rst_n mid-sweep aborts the sweep with no partial done.
//   FSM states: IDLE, SETTLE, CHECK, DONE.
//   IDLE/DONE
//     - start=1 at an edge: go to SETTLE, vec_out<=0, settle counter<=SETTLE_CYC-1.
//     - Also clear err_cnt, first_err_valid, first_err_vec, done and pass.
//     - busy=1 from that edge.
//   SETTLE
//     - Counter decrements each edge. When it is 0, go to CHECK.
//     - vec_out holds for SETTLE_CYC cycles.
//   CHECK (one cycle)
//     - At the ending edge, compare dut_y against TRUTH[vec_out].
//     - Mismatch: err_cnt+1, held at 2^ERR_W-1 once saturated.
//     - First mismatch only: first_err_valid<=1, first_err_vec<=vec_out.
//   CHECK exit
//     - If vec_out == all-ones: go to DONE; busy<=0, done<=1, pass<=(no mismatch in sweep).
//     - pass is computed from an internal any-error flag, not from saturated err_cnt.
//     - Else: vec_out<=vec_out+1 and go back to SETTLE with the counter reloaded.
//     - vec_out never wraps within a sweep.
//   Latency
//     - done rises exactly 2^N_IN*(SETTLE_CYC+1) edges after the edge that accepts start.
//     - Defaults give 8 edges.
//   start
//     - Ignored while busy; the sweep continues unchanged.
//     - start held high in DONE restarts every accepted edge (back-to-back sweeps).
//   Stability
//     - vec_out changes only on edges leaving CHECK or accepting start, never inside a vector window.
//     - dut_y is sampled only at the CHECK-ending edge; it may glitch in SETTLE without effect.
//     - DONE holds vec_out at all-ones and all results stable until the next start or reset.
// TESTING
//   1. Defaults, dut_y=&vec_out, start pulse -> vec 0,1,2,3 at 2 cycles each; done at +8; pass=1; err_cnt=0; first_err_valid=0.
//   2. dut_y stuck 0 -> err_cnt=1, first_err_vec=2'b11, pass=0.
//   3. dut_y stuck 1 -> err_cnt=3, first_err_vec=2'b00, pass=0.
//   4. ERR_W=2, dut_y=~&vec_out -> 4 mismatches; err_cnt saturates at 2'b11; pass=0.
//   5. start re-pulsed at cycle 3 of a sweep -> ignored; done still at +8 from the first start.
//   6. rst_n low at cycle 5 -> all outputs 0 at once; after release, new start gives a clean sweep with scenario 1 results.

Source files
------------

// File: rtl/gate_response_checker.sv
// Sweeps every input vector of a 2^N_IN-row gate, checks the sampled output
// against a truth table and reports mismatch count and first failing vector.
module gate_response_checker #(
    parameter int                     N_IN       = 2,
    parameter logic [(1<<N_IN)-1:0]   TRUTH      = 4'b1000,
    parameter int                     SETTLE_CYC = 1,
    parameter int                     ERR_W      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dut_y,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic            first_err_valid,
    output logic [N_IN-1:0] first_err_vec
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CNT_W-1:0] cnt;
    logic            any_err;
    logic            accept;
    logic            last_vec;
    logic            mismatch;

    assign last_vec = (vec_out == {N_IN{1'b1}});
    assign mismatch = (state == CHECK) && (dut_y != TRUTH[vec_out]);
    assign busy     = (state == SETTLE) || (state == CHECK);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                state_nxt = last_vec ? DONE : SETTLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: vector sweep, settle timer and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out         <= '0;
            cnt             <= '0;
            err_cnt         <= '0;
            any_err         <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            pass            <= 1'b0;
        end else if (accept) begin
            vec_out         <= '0;
            cnt             <= CNT_LD;
            err_cnt         <= '0;
            any_err         <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            pass            <= 1'b0;
        end else begin
            if (state == SETTLE && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == CHECK) begin
                if (mismatch) begin
                    any_err <= 1'b1;
                    if (err_cnt != {ERR_W{1'b1}}) begin
                        err_cnt <= err_cnt + ERR_W'(1);
                    end
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_vec   <= vec_out;
                    end
                end
                if (last_vec) begin
                    // Saturated err_cnt cannot be trusted here, use the sticky flag
                    pass <= !(any_err || mismatch);
                end else begin
                    vec_out <= vec_out + N_IN'(1);
                    cnt     <= CNT_LD;
                end
            end
        end
    end

endmodule
